// File: rtl/signed_accumulator.sv
// Sums NUMBER_OF_SAMPLES signed samples and holds each result until it is consumed.
// Valid/ready on both sides; a synchronous clear aborts any partial or held sum.
module signed_accumulator #(
  parameter int WIDTH_OF_INPUT_DATA  = 8,
  parameter int WIDTH_OF_OUTPUT_DATA = 16,
  parameter int NUMBER_OF_SAMPLES    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH_OF_INPUT_DATA-1:0]  input_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH_OF_OUTPUT_DATA-1:0] output_data
);

  localparam int CountWidth = $clog2(NUMBER_OF_SAMPLES + 1);
  localparam int ExtWidth   = WIDTH_OF_OUTPUT_DATA - WIDTH_OF_INPUT_DATA;
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(NUMBER_OF_SAMPLES - 1);

  typedef enum logic {
    ACCUM,
    DONE
  } state_e;

  state_e                          state_q, state_d;
  logic [WIDTH_OF_OUTPUT_DATA-1:0] accum_q, accum_d;
  logic [CountWidth-1:0]           count_q, count_d;
  logic [WIDTH_OF_OUTPUT_DATA-1:0] sampleExt;

  assign sampleExt = {{ExtWidth{input_data[WIDTH_OF_INPUT_DATA-1]}}, input_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      accum_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      accum_q <= accum_d;
      count_q <= count_d;
    end
  end

  // clear outranks both a sample acceptance and an output handshake
  always_comb begin
    state_d = state_q;
    accum_d = accum_q;
    count_d = count_q;
    if (clear) begin
      state_d = ACCUM;
      accum_d = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            accum_d = accum_q + sampleExt;
            if (count_q == LastCount) begin
              state_d = DONE;
              count_d = '0;
            end else begin
              count_d = count_q + CountWidth'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = ACCUM;
            accum_d = '0;
          end
        end
        default: begin
          state_d = ACCUM;
          accum_d = '0;
          count_d = '0;
        end
      endcase
    end
  end

  // partial sums stay hidden: output_data is only non-zero while a result is held
  always_comb begin
    in_ready    = (state_q == ACCUM);
    out_valid   = (state_q == DONE);
    output_data = (state_q == DONE) ? accum_q : '0;
  end

endmodule

// File: tb/tb_signed_accumulator.sv
// Scoreboard bench for signed_accumulator: a behavioural model pushes each expected
// sum when the completing sample is driven; held results are compared every cycle.
module tb_signed_accumulator;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  input_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] output_data;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expQ[$];
  int          modelCount;
  int          modelSum;
  bit          modelDone;

  signed_accumulator #(
    .WIDTH_OF_INPUT_DATA (8),
    .WIDTH_OF_OUTPUT_DATA(16),
    .NUMBER_OF_SAMPLES   (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .input_data (input_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .output_data(output_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    modelCount = 0;
    modelSum   = 0;
    modelDone  = 1'b0;
    expQ.delete();
  endtask

  // One clock cycle: drive, compare against the model at negedge, then advance the model.
  task automatic applyStimulus(input logic clr, input logic v, input logic [7:0] d,
                               input logic ordy);
    logic [15:0] expData;
    clear      = clr;
    in_valid   = v;
    input_data = d;
    out_ready  = ordy;
    @(negedge clk);
    expData = (modelDone && expQ.size() > 0) ? expQ[0] : 16'h0000;
    checkOutput("in_ready", in_ready, !modelDone);
    checkOutput("out_valid", out_valid, modelDone);
    checkOutput("output_data", output_data, expData);
    @(posedge clk);
    if (clr) begin
      if (modelDone && expQ.size() > 0) void'(expQ.pop_front());
      modelCount = 0;
      modelSum   = 0;
      modelDone  = 1'b0;
    end else if (!modelDone) begin
      if (v) begin
        modelSum += int'($signed(d));
        modelCount++;
        if (modelCount == N) begin
          expQ.push_back(16'(modelSum));
          modelSum   = 0;
          modelCount = 0;
          modelDone  = 1'b1;
        end
      end
    end else if (ordy) begin
      if (expQ.size() > 0) void'(expQ.pop_front());
      modelDone = 1'b0;
    end
    #1;
  endtask

  task automatic feedSamples(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3, input logic ordy);
    applyStimulus(1'b0, 1'b1, s0, ordy);
    applyStimulus(1'b0, 1'b1, s1, ordy);
    applyStimulus(1'b0, 1'b1, s2, ordy);
    applyStimulus(1'b0, 1'b1, s3, ordy);
  endtask

  task automatic checkResult(input string tag, input logic [15:0] exp);
    checkOutput({tag, "_valid"}, out_valid, 1'b1);
    checkOutput(tag, output_data, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    input_data = 8'h00;
    out_ready  = 1'b0;
    modelReset();
    #2;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_output_data", output_data, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    feedSamples(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    checkResult("r028_sum", 16'h000A);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("r028_accum", in_ready, 1'b1);

    feedSamples(8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
    checkResult("r029_neg", 16'hFE00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    feedSamples(8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1);
    checkResult("r029_pos", 16'h01FC);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    feedSamples(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkResult("r030_hold", 16'h000A);
      checkOutput("r030_in_ready", in_ready, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h55, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
    feedSamples(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
    checkResult("r030_fresh", 16'h0004);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    applyStimulus(1'b0, 1'b1, 8'd7, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd7, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd9, 1'b1);
    feedSamples(8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
    checkResult("r031_sum", 16'h0014);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    applyStimulus(1'b0, 1'b1, 8'd3, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd3, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd3, 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("r032_in_ready", in_ready, 1'b1);
    checkOutput("r032_out_valid", out_valid, 1'b0);
    checkOutput("r032_output_data", output_data, 16'h0000);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    feedSamples(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    checkResult("r032_sum", 16'hFFFC);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    applyStimulus(1'b0, 1'b1, 8'd2, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h77, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h77, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hFA, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h77, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h77, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'd4, 1'b1);
    checkResult("r033_sum", 16'h0001);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    feedSamples(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("clr_done_valid", out_valid, 1'b0);
    checkOutput("clr_done_data", output_data, 16'h0000);
    feedSamples(8'd6, 8'd6, 8'd6, 8'd6, 1'b1);
    checkResult("clr_done_next", 16'h0018);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                    8'($urandom), 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
